// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered issue stage feeding the combinational ALU.
// Two-entry skid buffer keeps full rate under consumer backpressure.
module alu_operand_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [IMM_WIDTH-1:0] in_imm,
  input  logic                 in_useImm,
  input  logic                 in_immSext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           AluOp,
  output logic [WIDTH-1:0]     busA,
  output logic [WIDTH-1:0]     busB
);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  entry_t mEnt, sEnt, inEnt, mNext, sNext;
  logic mValid, sValid, mValidNext, sValidNext;
  logic readyQ, accept, fire;
  logic [WIDTH-1:0] immExt;
  logic immFill;

  assign immFill = in_immSext & in_imm[IMM_WIDTH-1];
  assign immExt  = {{(WIDTH-IMM_WIDTH){immFill}}, in_imm};

  assign inEnt.op = in_op;
  assign inEnt.a  = in_a;
  assign inEnt.b  = in_useImm ? immExt : in_b;

  assign accept = in_valid & readyQ;
  assign fire   = mValid & out_ready;

  assign in_ready  = readyQ;
  assign out_valid = mValid;
  assign AluOp     = mEnt.op;
  assign busA      = mEnt.a;
  assign busB      = mEnt.b;

  // Next-state of the main and skid entries; vacated entries are zeroed
  always_comb begin
    mNext      = mEnt;
    sNext      = sEnt;
    mValidNext = mValid;
    sValidNext = sValid;
    unique case (1'b1)
      !mValid: begin
        if (accept) begin
          mNext      = inEnt;
          mValidNext = 1'b1;
        end
      end
      fire && sValid: begin
        mNext = sEnt;
        if (accept) begin
          sNext = inEnt;
        end else begin
          sNext      = '0;
          sValidNext = 1'b0;
        end
      end
      fire && !sValid: begin
        if (accept) begin
          mNext = inEnt;
        end else begin
          mNext      = '0;
          mValidNext = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          sNext      = inEnt;
          sValidNext = 1'b1;
        end
      end
    endcase
  end

  // Pipeline registers; reset beats flush, flush beats handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      mEnt   <= '0;
      sEnt   <= '0;
      mValid <= 1'b0;
      sValid <= 1'b0;
      readyQ <= 1'b0;
    end else if (flush) begin
      mEnt   <= '0;
      sEnt   <= '0;
      mValid <= 1'b0;
      sValid <= 1'b0;
      readyQ <= 1'b1;
    end else begin
      mEnt   <= mNext;
      sEnt   <= sNext;
      mValid <= mValidNext;
      sValid <= sValidNext;
      readyQ <= !sValidNext;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with a queued scoreboard.
// A negedge monitor pops expected ops whenever the DUT fires.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [15:0] in_imm;
  logic        in_useImm, in_immSext;
  logic        out_valid, out_ready;
  logic [3:0]  AluOp;
  logic [31:0] busA, busB;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .IMM_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_imm(in_imm), .in_useImm(in_useImm),
    .in_immSext(in_immSext),
    .out_valid(out_valid), .out_ready(out_ready),
    .AluOp(AluOp), .busA(busA), .busB(busB)
  );

  task automatic check(input string name,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op,
                      input logic [31:0] a, b,
                      input logic [15:0] imm,
                      input logic useImm, sext,
                      input logic [31:0] expB,
                      output int waits);
    exp_t e;
    in_op = op; in_a = a; in_b = b;
    in_imm = imm; in_useImm = useImm;
    in_immSext = sext; in_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush && !rst) begin
          e.op = op; e.a = a; e.b = expB;
          q.push_back(e);
        end
        tick();
        return;
      end
      tick();
      waits++;
    end
    errors++;
    $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles", waits);
  endtask

  // Monitor: scoreboard pops, zero-when-idle, hold-when-stalled
  logic        prevHold = 1'b0;
  logic [71:0] prevOut;
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (prevHold)
        check("hold", {out_valid, AluOp, busA, busB},
              {1'b1, prevOut[67:0]});
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_out: op %h a %h b %h",
                     AluOp, busA, busB);
          end else begin
            e = q.pop_front();
            check("scoreboard", {AluOp, busA, busB},
                  {e.op, e.a, e.b});
          end
        end
      end else begin
        check("idle_zero", {AluOp, busA, busB}, 72'd0);
      end
    end
    prevHold = out_valid && !out_ready && !rst && !flush;
    prevOut  = {4'd0, AluOp, busA, busB};
  end

  initial begin
    int w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_imm = '0;
    in_useImm = 1'b0; in_immSext = 1'b0;
    out_ready = 1'b1;

    tick(); tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out", {out_valid, AluOp, busA, busB}, 72'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
    tick();

    // single op, one-cycle latency
    send(4'b0100, 32'd10, 32'd15, 16'd0, 1'b0, 1'b0, 32'd15, w);
    in_valid = 1'b0;
    check("single_valid", out_valid, 1'b1);
    check("single_sum", busA + busB, 32'd25);
    check("single_op", AluOp, 4'b0100);
    tick();
    check("single_drain", {out_valid, AluOp, busA, busB}, 72'd0);

    // immediate extension
    send(4'd0, 32'd1, 32'h1234, 16'hFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, w);
    check("imm_sext", busB, 32'hFFFFFFFF);
    send(4'd0, 32'd2, 32'h1234, 16'hFFFF, 1'b1, 1'b0, 32'h0000FFFF, w);
    check("imm_zext", busB, 32'h0000FFFF);
    send(4'b1101, 32'h10000, 32'h55, 16'd1, 1'b1, 1'b0, 32'd1, w);
    check("imm_one", busB, 32'd1);
    send(4'd2, 32'd3, 32'h0, 16'h7FFF, 1'b1, 1'b1, 32'h00007FFF, w);
    check("imm_pos_sext", busB, 32'h00007FFF);
    send(4'd2, 32'd4, 32'hCAFE, 16'h8000, 1'b0, 1'b1, 32'hCAFE, w);
    check("reg_b", busB, 32'hCAFE);
    in_valid = 1'b0;
    repeat (3) tick();

    // backpressure and skid
    out_ready = 1'b0;
    send(4'd1, 32'd100, 32'd1, 16'd0, 1'b0, 1'b0, 32'd1, w);
    send(4'd2, 32'd200, 32'd2, 16'd0, 1'b0, 1'b0, 32'd2, w);
    in_op = 4'd3; in_a = 32'd300; in_b = 32'd3; in_useImm = 1'b0;
    @(negedge clk);
    check("skid_full_ready", in_ready, 1'b0);
    check("skid_m_busA", busA, 32'd100);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_ready", in_ready, 1'b0);
    tick();
    @(negedge clk);
    check("p2_out", {out_valid, busA}, {1'b1, 32'd200});
    check("p3_ready", in_ready, 1'b1);
    q.push_back('{op: 4'd3, a: 32'd300, b: 32'd3});
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("p3_out", {out_valid, busA}, {1'b1, 32'd300});
    tick();
    check("skid_drain", out_valid, 1'b0);

    // full-rate stream, last op an undefined opcode
    for (int i = 0; i < 8; i++) begin
      send((i == 7) ? 4'hF : 4'd3, i, i * 2, 16'd0,
           1'b0, 1'b0, i * 2, w);
      check("stream_nowait", w, 0);
      check("stream_out", {out_valid, busA}, {1'b1, 32'(i)});
    end
    in_valid = 1'b0;
    check("undef_op", AluOp, 4'hF);
    repeat (3) tick();

    // flush with both entries full plus a same-cycle input
    out_ready = 1'b0;
    send(4'd5, 32'd500, 32'd5, 16'd0, 1'b0, 1'b0, 32'd5, w);
    send(4'd6, 32'd600, 32'd6, 16'd0, 1'b0, 1'b0, 32'd6, w);
    in_op = 4'd7; in_a = 32'd700; in_b = 32'd7;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out", {out_valid, AluOp, busA, busB}, 72'd0);
    check("flush_ready", in_ready, 1'b1);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    send(4'd8, 32'd800, 32'd8, 16'd0, 1'b0, 1'b0, 32'd8, w);
    in_valid = 1'b0;
    check("post_flush_op", busA, 32'd800);
    repeat (2) tick();

    // reset beats flush with both entries full
    out_ready = 1'b0;
    send(4'd9, 32'd900, 32'd9, 16'd0, 1'b0, 1'b0, 32'd9, w);
    send(4'd10, 32'd1000, 32'd10, 16'd0, 1'b0, 1'b0, 32'd10, w);
    rst = 1'b1; flush = 1'b1;
    tick();
    @(negedge clk);
    check("rstpri_valid", out_valid, 1'b0);
    check("rstpri_ready", in_ready, 1'b0);
    check("rstpri_out", {AluOp, busA, busB}, 72'd0);
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("rstpri_release", in_ready, 1'b1);

    repeat (5) tick();
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
